// File: rtl/constraint_seq_checker_pkg.sv
// Shared types for the sequential constraint checker: opcodes, table entry layout and FSM states.
package constraint_pkg;
  localparam int unsigned DEF_NUM_VARS = 30;
  localparam int unsigned DEF_VAR_W    = 32;
  localparam int unsigned DEF_NUM_CONS = 30;
  localparam int unsigned VIDX_W       = $clog2(DEF_NUM_VARS);

  typedef enum logic [2:0] {
    TRUE   = 3'd0,
    NZ_A   = 3'd1,
    NZ_ADD = 3'd2,
    NE_AB  = 3'd3,
    LAND   = 3'd4,
    IMPL   = 3'd5,
    NZ_XOR = 3'd6,
    NE_K   = 3'd7
  } cons_op_e;

  typedef struct packed {
    cons_op_e              op;
    logic [VIDX_W-1:0]     a;
    logic [VIDX_W-1:0]     b;
    logic [DEF_VAR_W-1:0]  k;
  } cons_entry_t;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;
endpackage

// File: rtl/constraint_seq_checker_if.sv
// Config, sample and result channels of the constraint checker; master drives, slave is the checker.
interface constraint_seq_checker_if #(
  parameter int unsigned NUM_VARS = 30,
  parameter int unsigned VAR_W    = 32,
  parameter int unsigned NUM_CONS = 30,
  parameter int unsigned CNT_W    = 32
) ();
  localparam int unsigned CIDX_W = $clog2(NUM_CONS);
  localparam int unsigned VIDX_W = $clog2(NUM_VARS);

  logic                      cfg_we;
  logic [CIDX_W-1:0]         cfg_idx;
  logic [2:0]                cfg_op;
  logic [VIDX_W-1:0]         cfg_a;
  logic [VIDX_W-1:0]         cfg_b;
  logic [VAR_W-1:0]          cfg_k;
  logic                      cfg_err;
  logic                      s_valid;
  logic                      s_ready;
  logic [NUM_VARS*VAR_W-1:0] s_vars;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_sat;
  logic [NUM_CONS-1:0]       m_fail_mask;
  logic [CIDX_W-1:0]         m_first_fail;
  logic [CNT_W-1:0]          cnt_total;
  logic [CNT_W-1:0]          cnt_sat;

  modport master (
    output cfg_we, cfg_idx, cfg_op, cfg_a, cfg_b, cfg_k, s_valid, s_vars, m_ready,
    input  cfg_err, s_ready, m_valid, m_sat, m_fail_mask, m_first_fail, cnt_total, cnt_sat
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_op, cfg_a, cfg_b, cfg_k, s_valid, s_vars, m_ready,
    output cfg_err, s_ready, m_valid, m_sat, m_fail_mask, m_first_fail, cnt_total, cnt_sat
  );
endinterface

// File: rtl/constraint_seq_checker_eval_lane.sv
// One constraint evaluator: table entry plus the two selected operands in, pass bit out.
module constraint_eval_lane
  import constraint_pkg::*;
(
  input  cons_entry_t           entry_i,
  input  logic [DEF_VAR_W-1:0]  a_i,
  input  logic [DEF_VAR_W-1:0]  b_i,
  output logic                  pass_o
);
  logic [DEF_VAR_W-1:0] sum;
  // Operand indices are resolved by the caller; only the opcode and constant matter here.
  logic                 unused_idx;

  assign unused_idx = ^{entry_i.a, entry_i.b};

  always_comb begin
    sum    = a_i + entry_i.k;
    pass_o = 1'b1;
    case (entry_i.op)
      TRUE:    pass_o = 1'b1;
      NZ_A:    pass_o = (a_i != '0);
      NZ_ADD:  pass_o = (sum != '0);
      NE_AB:   pass_o = (a_i != b_i);
      LAND:    pass_o = (a_i != '0) && (b_i != '0);
      IMPL:    pass_o = (a_i == '0) || (b_i != '0);
      NZ_XOR:  pass_o = ((a_i ^ b_i) != '0);
      NE_K:    pass_o = (a_i != entry_i.k);
      default: pass_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/constraint_seq_checker.sv
// Sequential constraint checker: programmable table, LANES evaluations per cycle, result handshake
// and saturating sample counters.
module constraint_seq_checker
  import constraint_pkg::*;
#(
  parameter int unsigned NUM_VARS = DEF_NUM_VARS,
  parameter int unsigned VAR_W    = DEF_VAR_W,
  parameter int unsigned NUM_CONS = DEF_NUM_CONS,
  parameter int unsigned LANES    = 4,
  parameter int unsigned CNT_W    = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  constraint_seq_checker_if.slave bus
);
  localparam int unsigned CIDX_W = $clog2(NUM_CONS);
  localparam int unsigned PTR_W  = $clog2(NUM_CONS + LANES) + 1;

  state_e              state_q, state_d;
  cons_entry_t         table_q [NUM_CONS];
  logic [VAR_W-1:0]    vars_q  [NUM_VARS];
  logic [PTR_W-1:0]    ptr_q;
  logic [NUM_CONS-1:0] mask_q;
  logic [CIDX_W-1:0]   first_q, first_d;
  logic                sat_q;
  logic                cfg_err_q;
  logic [CNT_W-1:0]    cnt_total_q, cnt_sat_q;
  logic                accept, finalize, handshake, cfg_ok, cfg_apply;

  cons_entry_t         lane_entry [LANES];
  logic [VAR_W-1:0]    lane_a     [LANES];
  logic [VAR_W-1:0]    lane_b     [LANES];
  logic [LANES-1:0]    lane_pass;
  logic [NUM_CONS-1:0] beat_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // EVAL spends one extra cycle after the last beat so first_fail is encoded from the complete mask.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    finalize  = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: if (bus.s_valid) begin
        accept  = 1'b1;
        state_d = EVAL;
      end
      EVAL: if (32'(ptr_q) >= NUM_CONS) begin
        finalize = 1'b1;
        state_d  = DONE;
      end
      DONE: if (bus.m_ready) begin
        handshake = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_entry[l] = '{op: TRUE, default: '0};
      if (32'(ptr_q) + l < NUM_CONS) lane_entry[l] = table_q[CIDX_W'(32'(ptr_q) + l)];
      lane_a[l] = vars_q[lane_entry[l].a];
      lane_b[l] = vars_q[lane_entry[l].b];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    constraint_eval_lane u_lane (
      .entry_i (lane_entry[g]),
      .a_i     (lane_a[g]),
      .b_i     (lane_b[g]),
      .pass_o  (lane_pass[g])
    );
  end

  always_comb begin
    beat_fail = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if ((32'(ptr_q) + l < NUM_CONS) && !lane_pass[l]) beat_fail[CIDX_W'(32'(ptr_q) + l)] = 1'b1;
    end
  end

  // Scanning high-to-low lets the lowest set bit win.
  always_comb begin
    first_d = '0;
    for (int unsigned i = 0; i < NUM_CONS; i++) begin
      if (mask_q[NUM_CONS-1-i]) first_d = CIDX_W'(NUM_CONS-1-i);
    end
  end

  assign cfg_ok    = (32'(bus.cfg_idx) < NUM_CONS) && (32'(bus.cfg_a) < NUM_VARS) &&
                     (32'(bus.cfg_b) < NUM_VARS);
  assign cfg_apply = bus.cfg_we && cfg_ok && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CONS; i++) table_q[i] <= '{op: TRUE, default: '0};
      for (int unsigned i = 0; i < NUM_VARS; i++) vars_q[i] <= '0;
      ptr_q       <= '0;
      mask_q      <= '0;
      first_q     <= '0;
      sat_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_total_q <= '0;
      cnt_sat_q   <= '0;
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_apply;
      if (cfg_apply) begin
        table_q[bus.cfg_idx] <= '{op: cons_op_e'(bus.cfg_op), a: bus.cfg_a, b: bus.cfg_b, k: bus.cfg_k};
      end
      if (accept) begin
        for (int unsigned i = 0; i < NUM_VARS; i++) vars_q[i] <= bus.s_vars[i*VAR_W +: VAR_W];
        ptr_q  <= '0;
        mask_q <= '0;
      end else if ((state_q == EVAL) && !finalize) begin
        mask_q <= mask_q | beat_fail;
        ptr_q  <= ptr_q + PTR_W'(LANES);
      end
      if (finalize) begin
        sat_q   <= ~|mask_q;
        first_q <= first_d;
      end
      if (handshake) begin
        if (cnt_total_q != '1)          cnt_total_q <= cnt_total_q + CNT_W'(1);
        if (sat_q && (cnt_sat_q != '1)) cnt_sat_q   <= cnt_sat_q + CNT_W'(1);
      end
    end
  end

  assign bus.cfg_err      = cfg_err_q;
  assign bus.s_ready      = (state_q == IDLE);
  assign bus.m_valid      = (state_q == DONE);
  assign bus.m_sat        = sat_q;
  assign bus.m_fail_mask  = mask_q;
  assign bus.m_first_fail = first_q;
  assign bus.cnt_total    = cnt_total_q;
  assign bus.cnt_sat      = cnt_sat_q;
endmodule

// File: tb/tb_constraint_seq_checker.sv
// Table-driven bench for constraint_seq_checker with a result scoreboard and multi-cycle corner sequences.
module tb_constraint_seq_checker;
  import constraint_pkg::*;

  localparam int unsigned NV = 30;
  localparam int unsigned VW = 32;
  localparam int unsigned NC = 30;
  localparam int unsigned CW = 32;

  typedef logic [NV*VW-1:0] vars_t;
  typedef struct packed {
    logic [NC-1:0] mask;
    logic [4:0]    first;
    logic          sat;
  } res_t;
  typedef struct packed {
    vars_t vars;
    res_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  constraint_seq_checker_if #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .CNT_W(CW)) bus ();

  constraint_seq_checker #(
    .NUM_VARS (NV),
    .VAR_W    (VW),
    .NUM_CONS (NC),
    .LANES    (4),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          since_acc = 0;
  int unsigned exp_total = 0;
  int unsigned exp_sat   = 0;
  res_t        sb_q[$];
  vec_t        vecs[13];
  vars_t       base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since_acc++;
  endtask

  function automatic vars_t setv(input vars_t b, input int unsigned i, input logic [VW-1:0] val);
    vars_t r;
    r = b;
    r[i*VW +: VW] = val;
    return r;
  endfunction

  function automatic logic [NC-1:0] bitm(input int unsigned i);
    logic [NC-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input vars_t v, input logic [NC-1:0] m, input logic [4:0] f, input logic s);
    vec_t r;
    r.vars      = v;
    r.exp.mask  = m;
    r.exp.first = f;
    r.exp.sat   = s;
    return r;
  endfunction

  task automatic cfg_write(input int unsigned idx, input cons_op_e op, input int unsigned a,
                           input int unsigned b, input logic [VW-1:0] k, input logic exp_err,
                           input string name);
    bus.cfg_idx = 5'(idx);
    bus.cfg_op  = op;
    bus.cfg_a   = 5'(a);
    bus.cfg_b   = 5'(b);
    bus.cfg_k   = k;
    bus.cfg_we  = 1'b1;
    tick();
    bus.cfg_we  = 1'b0;
    check({name, "_cfg_err"}, 64'(bus.cfg_err), 64'(exp_err));
  endtask

  task automatic send(input vars_t v, input res_t exp);
    int n;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      tick();
      n++;
    end
    check("s_ready_before_send", 64'(bus.s_ready), 64'(1));
    sb_q.push_back(exp);
    bus.s_vars  = v;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    since_acc   = 0;
  endtask

  task automatic finish_sample(input string name, input int hold);
    res_t e;
    bus.m_ready = (hold == 0);
    while (!bus.m_valid && since_acc < 40) tick();
    check({name, "_latency"}, 64'(since_acc), 64'(9));
    check({name, "_sb_depth"}, 64'(sb_q.size()), 64'(1));
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({name, "_mask"}, 64'(bus.m_fail_mask), 64'(e.mask));
    check({name, "_first"}, 64'(bus.m_first_fail), 64'(e.first));
    check({name, "_sat"}, 64'(bus.m_sat), 64'(e.sat));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, "_hold_valid"}, 64'(bus.m_valid), 64'(1));
      check({name, "_hold_mask"}, 64'(bus.m_fail_mask), 64'(e.mask));
      check({name, "_hold_first"}, 64'(bus.m_first_fail), 64'(e.first));
      check({name, "_hold_s_ready"}, 64'(bus.s_ready), 64'(0));
      check({name, "_hold_cnt"}, 64'(bus.cnt_total), 64'(exp_total));
    end
    bus.m_ready = 1'b1;
    tick();
    exp_total++;
    if (e.sat) exp_sat++;
    check({name, "_cnt_total"}, 64'(bus.cnt_total), 64'(exp_total));
    check({name, "_cnt_sat"}, 64'(bus.cnt_sat), 64'(exp_sat));
    check({name, "_valid_clr"}, 64'(bus.m_valid), 64'(0));
    check({name, "_s_ready_back"}, 64'(bus.s_ready), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    bus.cfg_we  = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_op  = '0;
    bus.cfg_a   = '0;
    bus.cfg_b   = '0;
    bus.cfg_k   = '0;
    bus.s_valid = 1'b0;
    bus.s_vars  = '0;
    bus.m_ready = 1'b1;

    base = '0;
    base = setv(base, 6, 1);
    base = setv(base, 7, 1);
    base = setv(base, 8, 2);
    base = setv(base, 9, 1);
    base = setv(base, 10, 1);
    base = setv(base, 11, 3);
    base = setv(base, 12, 4);

    vecs[0]  = mk(base, '0, 5'd0, 1'b1);
    vecs[1]  = mk(setv(base, 3, 1), bitm(5), 5'd5, 1'b0);
    vecs[2]  = mk(setv(base, 3, 2), '0, 5'd0, 1'b1);
    vecs[3]  = mk(setv(setv(base, 0, 9), 4, 7), bitm(2) | bitm(29), 5'd2, 1'b0);
    vecs[4]  = mk(setv(base, 4, 7), bitm(29), 5'd29, 1'b0);
    vecs[5]  = mk(setv(base, 6, 0), bitm(10), 5'd10, 1'b0);
    vecs[6]  = mk(setv(base, 8, 1), bitm(11), 5'd11, 1'b0);
    vecs[7]  = mk(setv(base, 10, 0), bitm(12), 5'd12, 1'b0);
    vecs[8]  = mk(setv(base, 12, 3), bitm(13), 5'd13, 1'b0);
    vecs[9]  = mk(setv(base, 13, 32'h55), bitm(14), 5'd14, 1'b0);
    vecs[10] = mk(setv(setv(setv(base, 3, 1), 13, 32'h55), 0, 9), bitm(2) | bitm(5) | bitm(14), 5'd2, 1'b0);
    vecs[11] = mk(setv(setv(base, 0, 9), 1, 5), '0, 5'd0, 1'b1);
    vecs[12] = mk('0, bitm(10) | bitm(11) | bitm(12) | bitm(13), 5'd10, 1'b0);

    tick();
    tick();
    check("rst_s_ready", 64'(bus.s_ready), 64'(1));
    check("rst_m_valid", 64'(bus.m_valid), 64'(0));
    check("rst_m_sat", 64'(bus.m_sat), 64'(0));
    check("rst_mask", 64'(bus.m_fail_mask), 64'(0));
    check("rst_first", 64'(bus.m_first_fail), 64'(0));
    check("rst_cnt_total", 64'(bus.cnt_total), 64'(0));
    check("rst_cnt_sat", 64'(bus.cnt_sat), 64'(0));
    check("rst_cfg_err", 64'(bus.cfg_err), 64'(0));
    rst_n = 1'b1;

    send('0, '{mask: '0, first: 5'd0, sat: 1'b1});
    finish_sample("zeros_default", 0);

    cfg_write(5, NZ_ADD, 3, 0, 32'hFFFF_FFFF, 1'b0, "w5");
    cfg_write(2, IMPL, 0, 1, '0, 1'b0, "w2");
    cfg_write(29, NE_K, 4, 0, 32'd7, 1'b0, "w29");
    cfg_write(10, NZ_A, 6, 0, '0, 1'b0, "w10");
    cfg_write(11, NE_AB, 7, 8, '0, 1'b0, "w11");
    cfg_write(12, LAND, 9, 10, '0, 1'b0, "w12");
    cfg_write(13, NZ_XOR, 11, 12, '0, 1'b0, "w13");
    cfg_write(14, NE_K, 13, 0, 32'h55, 1'b0, "w14");

    for (int i = 0; i < 13; i++) begin
      send(vecs[i].vars, vecs[i].exp);
      finish_sample($sformatf("vec%0d", i), 0);
    end

    send(base, '{mask: '0, first: 5'd0, sat: 1'b1});
    finish_sample("hold", 5);

    send(vecs[1].vars, vecs[1].exp);
    tick();
    tick();
    cfg_write(5, TRUE, 0, 0, '0, 1'b1, "w5_in_eval");
    tick();
    check("eval_err_pulse_end", 64'(bus.cfg_err), 64'(0));
    finish_sample("eval_write", 0);

    cfg_write(30, TRUE, 0, 0, '0, 1'b1, "idx30");
    cfg_write(5, TRUE, 30, 0, '0, 1'b1, "a30");
    cfg_write(6, NZ_A, 0, 31, '0, 1'b1, "b31");
    send(vecs[1].vars, vecs[1].exp);
    finish_sample("after_drops", 0);

    bus.cfg_idx = 5'd20;
    bus.cfg_op  = NZ_A;
    bus.cfg_a   = 5'd20;
    bus.cfg_b   = 5'd0;
    bus.cfg_k   = '0;
    bus.cfg_we  = 1'b1;
    send(base, '{mask: bitm(20), first: 5'd20, sat: 1'b0});
    bus.cfg_we  = 1'b0;
    check("wr_accept_cfg_err", 64'(bus.cfg_err), 64'(0));
    finish_sample("wr_accept", 0);

    send(vecs[10].vars, vecs[10].exp);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'(1));
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'(0));
    check("mid_rst_cnt_total", 64'(bus.cnt_total), 64'(0));
    check("mid_rst_cnt_sat", 64'(bus.cnt_sat), 64'(0));
    check("mid_rst_mask", 64'(bus.m_fail_mask), 64'(0));
    rst_n = 1'b1;
    sb_q.delete();
    exp_total = 0;
    exp_sat   = 0;
    send(vecs[10].vars, '{mask: '0, first: 5'd0, sat: 1'b1});
    finish_sample("after_reset_table_true", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
